// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - round-robin arbiter and sequencer for the shared 2:1 mux path
module mux_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             sel,
  output logic [WIDTH-1:0] o,
  output logic             o_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(MAX_BURST - 1);

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       last, last_nxt;
  logic       beat;

  assign gnt_a = (state == GNT_A);
  assign gnt_b = (state == GNT_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      last    <= 1'b1;
      sel     <= 1'b0;
      o       <= '0;
      o_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      last    <= last_nxt;
      o_valid <= beat;
      if (beat) o <= (state == GNT_B) ? b : a;
      // sel follows the owner and keeps its value while idle
      if (state_nxt == GNT_A) sel <= 1'b0;
      else if (state_nxt == GNT_B) sel <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    beat      = 1'b0;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || last)) begin
          state_nxt = GNT_A;
          cnt_nxt   = 4'd0;
          last_nxt  = 1'b0;
        end else if (req_b) begin
          state_nxt = GNT_B;
          cnt_nxt   = 4'd0;
          last_nxt  = 1'b1;
        end
      end
      GNT_A: begin
        if (req_a) begin
          beat = 1'b1;
          if (cnt == CNT_LAST) begin
            cnt_nxt = 4'd0;
            if (req_b) begin
              state_nxt = GNT_B;
              last_nxt  = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end else begin
          cnt_nxt = 4'd0;
          if (req_b) begin
            state_nxt = GNT_B;
            last_nxt  = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      GNT_B: begin
        if (req_b) begin
          beat = 1'b1;
          if (cnt == CNT_LAST) begin
            cnt_nxt = 4'd0;
            if (req_a) begin
              state_nxt = GNT_A;
              last_nxt  = 1'b0;
            end
          end else begin
            cnt_nxt = cnt + 4'd1;
          end
        end else begin
          cnt_nxt = 4'd0;
          if (req_a) begin
            state_nxt = GNT_A;
            last_nxt  = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - directed self-checking bench for mux_arbiter
module tb_mux_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_a, req_b;
  logic [3:0] a, b;
  logic       gnt_a, gnt_b, sel, o_valid;
  logic [3:0] o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux_arbiter #(.WIDTH(4), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .a(a),
    .req_b(req_b), .b(b),
    .gnt_a(gnt_a), .gnt_b(gnt_b), .sel(sel),
    .o(o), .o_valid(o_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // drive inputs, then observe outputs just after the next rising edge
  task automatic cyc(input logic r, input logic ra, input logic [3:0] av,
                     input logic rb, input logic [3:0] bv);
    rst = r; req_a = ra; a = av; req_b = rb; b = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ga, input logic gb,
                            input logic s, input logic v, input logic [3:0] ov);
    check({tag, ".gnt_a"}, 32'(gnt_a), 32'(ga));
    check({tag, ".gnt_b"}, 32'(gnt_b), 32'(gb));
    check({tag, ".sel"}, 32'(sel), 32'(s));
    check({tag, ".o_valid"}, 32'(o_valid), 32'(v));
    check({tag, ".o"}, 32'(o), 32'(ov));
  endtask

  initial begin
    rst = 1'b1; req_a = 1'b0; req_b = 1'b0; a = '0; b = '0;
    #2;

    // reset held with both requests high
    cyc(1, 1, 4'h5, 1, 4'h3);
    expect_out("rst0", 0, 0, 0, 0, 4'h0);
    cyc(1, 1, 4'h5, 1, 4'h3);
    expect_out("rst1", 0, 0, 0, 0, 4'h0);
    cyc(0, 1, 4'h5, 1, 4'h3);
    expect_out("rel", 1, 0, 0, 0, 4'h0);
    cyc(0, 0, 4'h5, 0, 4'h3);
    expect_out("drop", 0, 0, 0, 0, 4'h0);

    // single requester A
    cyc(0, 1, 4'b1010, 0, 4'h0);
    expect_out("sgl.g", 1, 0, 0, 0, 4'h0);
    cyc(0, 1, 4'b1010, 0, 4'h0);
    expect_out("sgl.b0", 1, 0, 0, 1, 4'b1010);
    cyc(0, 1, 4'b0001, 0, 4'h0);
    expect_out("sgl.b1", 1, 0, 0, 1, 4'b0001);
    cyc(0, 1, 4'b1111, 0, 4'h0);
    expect_out("sgl.b2", 1, 0, 0, 1, 4'b1111);
    cyc(0, 0, 4'b0000, 0, 4'h0);
    expect_out("sgl.end", 0, 0, 0, 0, 4'b1111);

    // fair sharing from a fresh reset, A wins the tie
    cyc(1, 0, 4'h0, 0, 4'h0);
    expect_out("fair.rst", 0, 0, 0, 0, 4'h0);
    cyc(0, 1, 4'b1010, 1, 4'b0001);
    expect_out("fair.g", 1, 0, 0, 0, 4'h0);
    for (int k = 0; k < 16; k++) begin
      logic s_exp;
      s_exp = (((k + 1) / 4) % 2) != 0;
      cyc(0, 1, 4'b1010, 1, 4'b0001);
      expect_out($sformatf("fair%0d", k), !s_exp, s_exp, s_exp, 1,
                 ((k / 4) % 2 == 0) ? 4'b1010 : 4'b0001);
    end

    // burst renewal on B alone
    cyc(0, 0, 4'h0, 0, 4'h0);
    expect_out("ren.idle", 0, 0, 0, 0, 4'b0001);
    cyc(0, 0, 4'h0, 1, 4'h0);
    expect_out("ren.g", 0, 1, 1, 0, 4'b0001);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 4'h0, 1, 4'(k + 2));
      expect_out($sformatf("ren%0d", k), 0, 1, 1, 1, 4'(k + 2));
    end
    cyc(0, 0, 4'h0, 0, 4'h0);
    expect_out("ren.end", 0, 0, 1, 0, 4'hb);

    // early release of A while B waits
    cyc(0, 1, 4'b0011, 0, 4'h0);
    expect_out("erl.g", 1, 0, 0, 0, 4'hb);
    cyc(0, 1, 4'b0011, 1, 4'b0110);
    expect_out("erl.b0", 1, 0, 0, 1, 4'b0011);
    cyc(0, 1, 4'b0100, 1, 4'b0110);
    expect_out("erl.b1", 1, 0, 0, 1, 4'b0100);
    cyc(0, 0, 4'b0000, 1, 4'b0110);
    expect_out("erl.sw", 0, 1, 1, 0, 4'b0100);
    cyc(0, 0, 4'b0000, 1, 4'b0111);
    expect_out("erl.b_first", 0, 1, 1, 1, 4'b0111);

    // reset on what would be B's second beat
    cyc(1, 1, 4'b1100, 1, 4'b1000);
    expect_out("mid.rst", 0, 0, 0, 0, 4'h0);
    cyc(0, 1, 4'b1100, 1, 4'b1000);
    expect_out("mid.g", 1, 0, 0, 0, 4'h0);
    cyc(0, 1, 4'b1100, 1, 4'b1000);
    expect_out("mid.b0", 1, 0, 0, 1, 4'b1100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
